// File: rtl/flight_mode_sequencer.sv
// Auto/Critical mode sequencer: switch debounce, receiver-link watchdog, mode arbitration
// and frame-aligned output commit. Define FAILSAFE_LATCH_EN to make FAILSAFE terminal until reset.
module flight_mode_sequencer #(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned LINK_TIMEOUT    = 1000000,
    parameter int unsigned RECOVER_FRAMES  = 8,
    parameter int unsigned TO_W            = 20
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Mode_Sw,
    input  logic       Rec_Frame,
    input  logic       Critical_Req,
    input  logic       SD_Ready,
    input  logic       Frame_Sync,
    output logic       Auto,
    output logic       Critical,
    output logic [1:0] Mode_State,
    output logic       Link_Lost,
    output logic       Reject
);
    typedef enum logic [1:0] {
        S_MANUAL   = 2'b00,
        S_ASSIST   = 2'b01,
        S_AUTO     = 2'b10,
        S_FAILSAFE = 2'b11
    } mode_e;

    localparam logic [3:0]      DEB_N  = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0]      RC_N   = 8'(RECOVER_FRAMES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(LINK_TIMEOUT);
    localparam logic [TO_W-1:0] WD_ONE = TO_W'(1);

    mode_e           state_q, state_d;
    logic            deb_q, deb_d, deb_prev_q;
    logic [3:0]      dbc_q, dbc_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [7:0]      rc_q, rc_d;
    logic            lost_q, lost_d;
    logic            auto_q, auto_d, crit_q, crit_d;
    logic            reject_q, reject_d;
    logic            timeout;

    always_comb begin
        deb_d = deb_q;
        dbc_d = dbc_q;
        if (Rec_Frame) begin
            if (Mode_Sw != deb_q) begin
                if (dbc_q + 4'd1 == DEB_N) begin
                    deb_d = ~deb_q;
                    dbc_d = '0;
                end else begin
                    dbc_d = dbc_q + 4'd1;
                end
            end else begin
                dbc_d = '0;
            end
        end

        // A frame arriving on the timeout cycle keeps the link alive.
        timeout = !Rec_Frame && (wd_q == TO_MAX);
        if (Rec_Frame)          wd_d = '0;
        else if (wd_q == TO_MAX) wd_d = wd_q;
        else                    wd_d = wd_q + WD_ONE;

        lost_d = lost_q;
        rc_d   = rc_q;
        if (!lost_q) begin
            rc_d = '0;
            if (timeout) lost_d = 1'b1;
        end else if (Rec_Frame) begin
            if (rc_q + 8'd1 == RC_N) begin
                lost_d = 1'b0;
                rc_d   = '0;
            end else begin
                rc_d = rc_q + 8'd1;
            end
        end else if (timeout) begin
            rc_d = '0;
        end

        state_d  = state_q;
        reject_d = 1'b0;
        if (lost_q) begin
            state_d = S_FAILSAFE;
        end else if (state_q == S_FAILSAFE) begin
`ifdef FAILSAFE_LATCH_EN
            state_d = S_FAILSAFE;
`else
            if (!deb_q && !Critical_Req) state_d = S_MANUAL;
`endif
        end else if (Critical_Req) begin
            case (state_q)
                S_MANUAL: state_d = S_ASSIST;
                S_AUTO:   state_d = S_FAILSAFE;
                default:  state_d = state_q;
            endcase
        end else if (deb_q) begin
            state_d  = SD_Ready ? S_AUTO : S_MANUAL;
            reject_d = !SD_Ready && !deb_prev_q;
        end else begin
            state_d = S_MANUAL;
        end

        // Failsafe entry bypasses the frame boundary; everything else commits the current state.
        auto_d = auto_q;
        crit_d = crit_q;
        if (state_d == S_FAILSAFE && state_q != S_FAILSAFE) begin
            auto_d = 1'b1;
            crit_d = 1'b1;
        end else if (Frame_Sync) begin
            {auto_d, crit_d} = state_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_MANUAL;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            dbc_q      <= '0;
            wd_q       <= '0;
            rc_q       <= '0;
            lost_q     <= 1'b0;
            auto_q     <= 1'b0;
            crit_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dbc_q      <= dbc_d;
            wd_q       <= wd_d;
            rc_q       <= rc_d;
            lost_q     <= lost_d;
            auto_q     <= auto_d;
            crit_q     <= crit_d;
            reject_q   <= reject_d;
        end
    end

    assign Auto       = auto_q;
    assign Critical   = crit_q;
    assign Mode_State = state_q;
    assign Link_Lost  = lost_q;
    assign Reject     = reject_q;
endmodule
